// File: rtl/mem_req_arbiter.sv
// Two-port (instruction fetch / data) request arbiter in front of a single cache controller.
// One request is outstanding at a time; ISSUE is bounded by a TIMEOUT-cycle watchdog.
module mem_req_arbiter #(
    parameter int TIMEOUT = 1024
) (
    input  logic        sys_clk,
    input  logic        rstn,
    input  logic        if_valid,
    input  logic [31:0] if_addr,
    output logic        if_ready,
    output logic [31:0] if_rdata,
    input  logic        d_valid,
    input  logic        d_rw,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ready,
    output logic [31:0] d_rdata,
    output logic        err,
    output logic [26:0] addr_dram,
    output logic [31:0] din_dram,
    output logic        rw_dram,
    output logic        valid_dram,
    input  logic [31:0] dout_dram,
    input  logic        ready_dram
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic        GRANT_IF = 1'b0;
    localparam logic        GRANT_D  = 1'b1;
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    // Word-aligned and inside the 128 MiB window the cache controller can address.
    function automatic logic addr_bad(input logic [31:0] addr);
        return (addr[1:0] != 2'b00) || (addr[31:27] != 5'b00000);
    endfunction

    state_t      state_r, next_state_s;
    logic [15:0] cnt_r, cnt_nxt_s;
    logic        last_grant_r, last_grant_nxt_s;
    logic        port_r, port_nxt_s;
    logic [26:0] addr_r, addr_nxt_s;
    logic [31:0] din_r, din_nxt_s;
    logic        rw_r, rw_nxt_s;
    logic        valid_r, valid_nxt_s;
    logic        if_ready_r, d_ready_r, err_r;
    logic [31:0] if_rdata_r, d_rdata_r;

    logic        grant_d_s;
    logic [31:0] sel_addr_s;
    logic        pulse_s, pulse_port_s, pulse_err_s;
    logic [31:0] pulse_rdata_s;

    assign grant_d_s  = d_valid && (!if_valid || (last_grant_r == GRANT_IF));
    assign sel_addr_s = grant_d_s ? d_addr : if_addr;

    // Next-state, request-register and completion-pulse decode.
    always_comb begin
        next_state_s     = state_r;
        cnt_nxt_s        = cnt_r;
        last_grant_nxt_s = last_grant_r;
        port_nxt_s       = port_r;
        addr_nxt_s       = addr_r;
        din_nxt_s        = din_r;
        rw_nxt_s         = rw_r;
        valid_nxt_s      = 1'b0;
        pulse_s          = 1'b0;
        pulse_port_s     = port_r;
        pulse_err_s      = 1'b0;
        pulse_rdata_s    = 32'd0;
        case (state_r)
            ST_IDLE: begin
                if (if_valid || d_valid) begin
                    last_grant_nxt_s = grant_d_s ? GRANT_D : GRANT_IF;
                    port_nxt_s       = grant_d_s ? GRANT_D : GRANT_IF;
                    addr_nxt_s       = sel_addr_s[26:0];
                    din_nxt_s        = grant_d_s ? d_wdata : 32'd0;
                    rw_nxt_s         = grant_d_s & d_rw;
                    if (addr_bad(sel_addr_s)) begin
                        next_state_s = ST_DONE;
                        pulse_s      = 1'b1;
                        pulse_port_s = grant_d_s ? GRANT_D : GRANT_IF;
                        pulse_err_s  = 1'b1;
                    end else begin
                        next_state_s = ST_ISSUE;
                        valid_nxt_s  = 1'b1;
                        cnt_nxt_s    = 16'd0;
                    end
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                cnt_nxt_s = cnt_r + 16'd1;
                // A late completion on the last allowed cycle wins over the watchdog.
                if (ready_dram) begin
                    next_state_s  = ST_DONE;
                    pulse_s       = 1'b1;
                    pulse_rdata_s = rw_r ? 32'd0 : dout_dram;
                end else if (cnt_r == CNT_LAST) begin
                    next_state_s = ST_DONE;
                    pulse_s      = 1'b1;
                    pulse_err_s  = 1'b1;
                end else begin
                    valid_nxt_s = 1'b1;
                end
            end
            ST_DONE: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State, request register and registered outputs.
    always_ff @(posedge sys_clk) begin
        if (!rstn) begin
            state_r      <= ST_IDLE;
            cnt_r        <= 16'd0;
            last_grant_r <= GRANT_IF;
            port_r       <= GRANT_IF;
            addr_r       <= 27'd0;
            din_r        <= 32'd0;
            rw_r         <= 1'b0;
            valid_r      <= 1'b0;
            if_ready_r   <= 1'b0;
            d_ready_r    <= 1'b0;
            err_r        <= 1'b0;
            if_rdata_r   <= 32'd0;
            d_rdata_r    <= 32'd0;
        end else begin
            state_r      <= next_state_s;
            cnt_r        <= cnt_nxt_s;
            last_grant_r <= last_grant_nxt_s;
            port_r       <= port_nxt_s;
            addr_r       <= addr_nxt_s;
            din_r        <= din_nxt_s;
            rw_r         <= rw_nxt_s;
            valid_r      <= valid_nxt_s;
            if_ready_r   <= pulse_s && (pulse_port_s == GRANT_IF);
            d_ready_r    <= pulse_s && (pulse_port_s == GRANT_D);
            err_r        <= pulse_s && pulse_err_s;
            if_rdata_r   <= (pulse_s && (pulse_port_s == GRANT_IF)) ? pulse_rdata_s : 32'd0;
            d_rdata_r    <= (pulse_s && (pulse_port_s == GRANT_D)) ? pulse_rdata_s : 32'd0;
        end
    end

    assign if_ready   = if_ready_r;
    assign if_rdata   = if_rdata_r;
    assign d_ready    = d_ready_r;
    assign d_rdata    = d_rdata_r;
    assign err        = err_r;
    assign addr_dram  = addr_r;
    assign din_dram   = din_r;
    assign rw_dram    = rw_r;
    assign valid_dram = valid_r;

endmodule
